resp_misr_compactor: RTL and testbench
======================================

// Module: resp_misr_compactor
// PURPOSE
//   Downstream response stage for the gate-level fault-sim harness. It consumes the
//   circuit-under-test output stream (pattout, one word per applied pattern) and
//   compacts it into a multiple-input signature register (MISR). After a
//   programmed number of patterns it compares the final signature against a
//   golden value. A single pass/fail bit then stands in for per-pattern compare.
// PARAMETERS
//   WIDTH         16        MISR width in bits (>= IN_WIDTH, >= 2)
//   IN_WIDTH      1         response bits per pattern (CUT output count)
//   POLY          16'h002D  feedback taps; bit i set => sig[W-1] XORed into bit i; POLY[0] must be 1
//   SEED          16'h0000  signature value loaded on start
//   NUM_PATTERNS  16        responses accepted per run (>= 1)
// PORTS
//   clk         input   1         rising-edge clock
//   rst         input   1         synchronous, active-high reset
//   start       input   1         begin a run (sampled in IDLE or DONE only)
//   resp_valid  input   1         resp_in carries a valid CUT response
//   resp_in     input   IN_WIDTH  CUT response word (pattout)
//   resp_ready  output  1         stage accepts a response this cycle
//   golden      input   WIDTH     expected final signature (held stable during a run)
//   signature   output  WIDTH     current MISR contents
//   pat_cnt     output  CW        responses accepted this run, CW = $clog2(NUM_PATTERNS+1)
//   busy        output  1         high in RUN
//   done        output  1         high in DONE
//   pass        output  1         signature==golden, valid while done
// BEHAVIOUR
//   Reset (rst=1 at a clk edge, any state, including mid-run):
//     state=IDLE, signature=SEED, pat_cnt=0, busy=0, done=0, pass=0, resp_ready=0.
//   FSM states: IDLE, RUN, DONE.
//     IDLE -start-> RUN: signature<=SEED, pat_cnt<=0.
//     RUN: resp_ready=1 (combinational from state). An accept is a cycle with
//       resp_valid && resp_ready. On an accept, signature<=misr_next and pat_cnt<=pat_cnt+1.
//       If the accept has pat_cnt==NUM_PATTERNS-1, state<=DONE and pass<=(misr_next==golden).
//       With no accept, all state holds. start is ignored in RUN.
//     DONE: signature, pat_cnt and pass hold. done=1. resp_ready=0.
//       DONE -start-> RUN: re-seed signature, pat_cnt<=0, pass<=0.
//   MISR update (Galois form). f = signature[W-1]; in_ext = resp_in zero-extended to WIDTH:
//     misr_next[0] = (POLY[0]&f) ^ in_ext[0]
//     misr_next[i] = signature[i-1] ^ (POLY[i]&f) ^ in_ext[i],  for i = 1..W-1
//   Latency: the accept at edge k sets the signature at edge k. done and pass are
//     visible in the cycle after the final accept.
//   Boundaries:
//     - resp_valid in IDLE/DONE: dropped (ready=0), nothing changes.
//     - A response accepted in RUN is never lost. resp_valid may gap for arbitrary cycles.
//     - NUM_PATTERNS=1: one accept goes straight to DONE.
//     - rst and start in the same cycle: rst wins.
//     - pat_cnt never exceeds NUM_PATTERNS. There is no wrap.
//     - golden is sampled only at the final accept.
// TESTING
//   T1 reset: rst high 2 cycles, then low with no start -> signature=SEED, pat_cnt=0,
//      done=0, pass=0, busy=0, resp_ready=0.
//   T2 known vector: W=4, IN=1, POLY=4'b0011, SEED=0, N=5; start; stream 1,0,0,0,0
//      -> signatures 0001,0010,0100,1000,0011; done=1 the next cycle. golden=4'h3 -> pass=1.
//   T3 mismatch: same as T2 with golden=4'h2 -> done=1, pass=0, signature=4'h3.
//   T4 backpressure/gaps: T2 stream with resp_valid low 3 cycles between each word
//      -> same final 4'h3. pat_cnt steps only on accepts.
//      resp_valid in DONE -> signature unchanged.
//   T5 reset mid-run: rst after the 3rd accept of T2 -> IDLE, signature=0, pat_cnt=0.
//      A fresh start plus the full T2 stream -> 4'h3, pass=1.
//   T6 rerun: from DONE assert start -> pass=0, pat_cnt=0, signature=SEED the next cycle.
//      Stream all zeros (N=5) -> signature=0000. golden=0 -> pass=1.

Source files
------------

// File: rtl/resp_misr_compactor.sv
// resp_misr_compactor: compacts the CUT response stream into a Galois-form MISR
// and compares the final signature against a golden value after a fixed number
// of accepted responses. The single pass bit replaces per-pattern comparison.
`timescale 1ns/1ps
module resp_misr_compactor #(
   parameter int unsigned           WIDTH        = 16,
   parameter int unsigned           IN_WIDTH     = 1,
   parameter logic [WIDTH-1:0]      POLY         = 16'h002D,
   parameter logic [WIDTH-1:0]      SEED         = 16'h0000,
   parameter int unsigned           NUM_PATTERNS = 16,
   localparam int unsigned          CW           = $clog2(NUM_PATTERNS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                resp_valid,
   input  logic [IN_WIDTH-1:0] resp_in,
   output logic                resp_ready,
   input  logic [WIDTH-1:0]    golden,
   output logic [WIDTH-1:0]    signature,
   output logic [CW-1:0]       pat_cnt,
   output logic                busy,
   output logic                done,
   output logic                pass
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);

   state_t           state;
   state_t           state_next;
   logic             load_seed;
   logic             accept;
   logic             last_accept;
   logic [WIDTH-1:0] in_ext;
   logic [WIDTH-1:0] misr_next;
   logic             fb;

   // Zero-extend the response word and compute the Galois MISR step.
   always_comb begin
      in_ext                = '0;
      in_ext[IN_WIDTH-1:0]  = resp_in;
      fb                    = signature[WIDTH-1];
      misr_next             = '0;
      misr_next[0]          = (POLY[0] & fb) ^ in_ext[0];
      for (int unsigned i = 1; i < WIDTH; i++) begin
         misr_next[i] = signature[i-1] ^ (POLY[i] & fb) ^ in_ext[i];
      end
   end

   // State register; reset forces IDLE from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and datapath control strobes.
   always_comb begin
      state_next  = state;
      load_seed   = 1'b0;
      accept      = 1'b0;
      last_accept = 1'b0;
      resp_ready  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load_seed  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            resp_ready = 1'b1;
            busy       = 1'b1;
            if (resp_valid) begin
               accept = 1'b1;
               if (pat_cnt == LAST_CNT) begin
                  last_accept = 1'b1;
                  state_next  = DONE;
               end
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load_seed  = 1'b1;
               state_next = RUN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Signature, accept counter and pass flag; everything holds without a strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         signature <= SEED;
         pat_cnt   <= '0;
         pass      <= 1'b0;
      end else if (load_seed) begin
         signature <= SEED;
         pat_cnt   <= '0;
         pass      <= 1'b0;
      end else if (accept) begin
         signature <= misr_next;
         pat_cnt   <= pat_cnt + 1'b1;
         if (last_accept) begin
            pass <= (misr_next == golden);
         end
      end
   end

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Self-checking bench for resp_misr_compactor: directed tests with literal
// expectations plus a randomized phase compared every cycle against a model.
`timescale 1ns/1ps
module tb_resp_misr_compactor;

   localparam int unsigned W  = 4;
   localparam int unsigned IW = 1;
   localparam logic [W-1:0] P = 4'b0011;
   localparam logic [W-1:0] S = 4'b0000;
   localparam int unsigned N  = 5;
   localparam int unsigned CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          resp_valid = 1'b0;
   logic [IW-1:0] resp_in = '0;
   logic          resp_ready;
   logic [W-1:0]  golden = '0;
   logic [W-1:0]  signature;
   logic [CW-1:0] pat_cnt;
   logic          busy;
   logic          done;
   logic          pass;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   resp_misr_compactor #(
      .WIDTH(W), .IN_WIDTH(IW), .POLY(P), .SEED(S), .NUM_PATTERNS(N)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid),
      .resp_in(resp_in), .resp_ready(resp_ready), .golden(golden),
      .signature(signature), .pat_cnt(pat_cnt), .busy(busy),
      .done(done), .pass(pass)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a run is "running" or "finished"; the signature is a
   // shift-left with polynomial feedback plus the response word.
   int m_sig = 0, m_cnt = 0;
   bit m_running = 0, m_finished = 0, m_pass = 0;

   function automatic int misr_step(input int s, input int din);
      int r;
      r = (s << 1) & ((1 << W) - 1);
      if (s >= (1 << (W - 1))) r = r ^ int'(P);
      return r ^ din;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_sig = int'(S); m_cnt = 0; m_running = 0; m_finished = 0; m_pass = 0;
      end else if (m_running) begin
         if (resp_valid) begin
            m_sig = misr_step(m_sig, int'(resp_in));
            m_cnt = m_cnt + 1;
            if (m_cnt == N) begin
               m_running = 0; m_finished = 1; m_pass = (m_sig == int'(golden));
            end
         end
      end else if (start) begin
         m_sig = int'(S); m_cnt = 0; m_running = 1; m_finished = 0; m_pass = 0;
      end
   end

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("signature", signature, m_sig);
         chk("pat_cnt", pat_cnt, m_cnt);
         chk("busy", busy, m_running);
         chk("resp_ready", resp_ready, m_running);
         chk("done", done, m_finished);
         chk("pass", pass, m_pass);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send(input logic b);
      resp_valid = 1'b1; resp_in = b; tick(); resp_valid = 1'b0; resp_in = '0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      rst = 1'b0;
   endtask

   logic [W-1:0] t2_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
   logic         t2_in  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      // T1 reset
      tick();
      chk_en = 1'b1;
      do_reset(2);
      tick();
      chk("t1_sig", signature, 4'h0);
      chk("t1_cnt", pat_cnt, 0);
      chk("t1_done", done, 0);
      chk("t1_pass", pass, 0);
      chk("t1_busy", busy, 0);
      chk("t1_ready", resp_ready, 0);
      // resp_valid while IDLE is dropped
      send(1'b1);
      chk("idle_drop_sig", signature, 4'h0);

      // T2 known vector, golden matches
      golden = 4'h3;
      pulse_start();
      chk("t2_busy", busy, 1);
      for (int k = 0; k < 5; k++) begin
         send(t2_in[k]);
         chk($sformatf("t2_sig%0d", k), signature, t2_exp[k]);
      end
      chk("t2_done", done, 1);
      chk("t2_pass", pass, 1);

      // T3 mismatch
      golden = 4'h2;
      pulse_start();
      for (int k = 0; k < 5; k++) send(t2_in[k]);
      chk("t3_done", done, 1);
      chk("t3_pass", pass, 0);
      chk("t3_sig", signature, 4'h3);

      // T4 gaps; start while running is ignored
      golden = 4'h3;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         send(t2_in[k]);
         chk($sformatf("t4_cnt%0d", k), pat_cnt, k + 1);
         for (int g = 0; g < 3; g++) begin
            if (g == 1 && k < 4) start = 1'b1;
            tick();
            start = 1'b0;
         end
         chk($sformatf("t4_hold%0d", k), pat_cnt, k + 1);
      end
      chk("t4_sig", signature, 4'h3);
      chk("t4_pass", pass, 1);
      send(1'b1);
      chk("t4_done_drop_sig", signature, 4'h3);
      chk("t4_done_drop_cnt", pat_cnt, 5);

      // T5 reset mid-run, rst wins over start
      pulse_start();
      for (int k = 0; k < 3; k++) send(t2_in[k]);
      chk("t5_mid_sig", signature, 4'h4);
      rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
      chk("t5_sig", signature, 4'h0);
      chk("t5_cnt", pat_cnt, 0);
      chk("t5_busy", busy, 0);
      pulse_start();
      for (int k = 0; k < 5; k++) send(t2_in[k]);
      chk("t5_final", signature, 4'h3);
      chk("t5_pass", pass, 1);

      // T6 rerun from DONE with all-zero stream
      golden = 4'h0;
      pulse_start();
      chk("t6_pass0", pass, 0);
      chk("t6_cnt0", pat_cnt, 0);
      chk("t6_seed", signature, 4'h0);
      for (int k = 0; k < 5; k++) send(1'b0);
      chk("t6_sig", signature, 4'h0);
      chk("t6_pass", pass, 1);

      // Randomized phase, checked by the per-cycle compare process.
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         start      = ($urandom_range(0, 5) == 0);
         resp_valid = ($urandom_range(0, 2) != 0);
         resp_in    = IW'($urandom);
         if (!m_running || $urandom_range(0, 9) == 0)
            golden = ($urandom_range(0, 3) == 0) ? 4'h0 : W'($urandom);
         tick();
      end
      rst = 1'b0; start = 1'b0; resp_valid = 1'b0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
